// File: rtl/ddr2_idelay_pkg.sv
// Shared definitions for the IDELAYCTRL reset sequencer and its users.
// Holds the sequencer state encoding and the default timing constants.
package ddr2_idelay_pkg;

    // Default timing in clk200 cycles
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned DEF_RST_CYCLES    = 12;   // IDELAYCTRL needs >= 50 ns (10 cycles)
    localparam int unsigned DEF_RDY_TIMEOUT   = 1024;
    localparam int unsigned DEF_MAX_RETRY     = 3;
    localparam int unsigned DEF_CNT_W         = 11;
    localparam int unsigned RETRY_W           = 2;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        RST_PULSE = 3'd2,
        WAIT_RDY  = 3'd3,
        READY     = 3'd4,
        FAIL      = 3'd5
    } idelay_state_e;

endpackage

// File: rtl/ddr2_sync2.sv
// Two-flop synchronizer with synchronous active-high reset to 0.
// Ports: clk, rst (sync, active-high), d (async input), q (synchronized output).
module ddr2_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ddr2_idelay_rst_seq.sv
// IDELAYCTRL reset sequencer in the 200 MHz reference domain: waits for a
// settled clock lock, pulses the IDELAYCTRL reset, waits for RDY with a
// timeout and bounded retries, and restarts on loss of RDY or lock.
// Ports:
//   clk200          200 MHz reference clock
//   rst200          synchronous active-high reset
//   clk_locked      DCM/PLL lock (asynchronous)
//   idelay_ctrl_rdy IDELAYCTRL RDY (asynchronous)
//   idelay_rst      IDELAYCTRL RST drive
//   iodelay_ready   IDELAYCTRL up and stable
//   timeout_err     sticky fatal error, cleared only by rst200
//   retry_count     timeouts seen in the current bring-up
module ddr2_idelay_rst_seq
    import ddr2_idelay_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned RDY_TIMEOUT   = DEF_RDY_TIMEOUT,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic               clk200,
    input  logic               rst200,
    input  logic               clk_locked,
    input  logic               idelay_ctrl_rdy,
    output logic               idelay_rst,
    output logic               iodelay_ready,
    output logic               timeout_err,
    output logic [RETRY_W-1:0] retry_count
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic lock_s;
    logic rdy_s;

    idelay_state_e      state;
    idelay_state_e      state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               idelay_rst_nxt;
    logic               iodelay_ready_nxt;
    logic               timeout_err_nxt;

    // Bring lock and RDY into the clk200 domain
    ddr2_sync2 u_sync_lock (
        .clk (clk200),
        .rst (rst200),
        .d   (clk_locked),
        .q   (lock_s)
    );

    ddr2_sync2 u_sync_rdy (
        .clk (clk200),
        .rst (rst200),
        .d   (idelay_ctrl_rdy),
        .q   (rdy_s)
    );

    // State, counter and output registers
    always_ff @(posedge clk200) begin
        if (rst200) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            retry_count   <= '0;
            idelay_rst    <= 1'b1;
            iodelay_ready <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry_count   <= retry_nxt;
            idelay_rst    <= idelay_rst_nxt;
            iodelay_ready <= iodelay_ready_nxt;
            timeout_err   <= timeout_err_nxt;
        end
    end

    // Next state; outputs are decoded from the next state so they line up
    // with the state register
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;

        case (state)
            WAIT_LOCK: begin
                if (lock_s) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!lock_s)                 state_nxt = WAIT_LOCK;
                else if (cnt == SETTLE_LAST) state_nxt = RST_PULSE;
            end
            RST_PULSE: begin
                if (!lock_s)              state_nxt = WAIT_LOCK;
                else if (cnt == RST_LAST) state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                // RDY wins over a timeout landing on the same cycle
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (rdy_s) begin
                    state_nxt = READY;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (32'(retry_count) < MAX_RETRY) begin
                        retry_nxt = retry_count + RETRY_W'(1);
                        state_nxt = RST_PULSE;
                    end else begin
                        state_nxt = FAIL;
                    end
                end
            end
            READY: begin
                if (!lock_s)     state_nxt = WAIT_LOCK;
                else if (!rdy_s) state_nxt = RST_PULSE;
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase

        if (state_nxt == WAIT_LOCK) retry_nxt = '0;

        // Counter restarts on every state change and saturates otherwise
        if (state_nxt != state || state == WAIT_LOCK) cnt_nxt = '0;
        else if (cnt == CNT_MAX)                      cnt_nxt = cnt;
        else                                          cnt_nxt = cnt + CNT_W'(1);

        idelay_rst_nxt    = !(state_nxt == WAIT_RDY || state_nxt == READY);
        iodelay_ready_nxt = (state_nxt == READY);
        timeout_err_nxt   = (state_nxt == FAIL);
    end

endmodule

// File: tb/tb_ddr2_idelay_rst_seq.sv
// Scoreboard bench for ddr2_idelay_rst_seq: stimulus pushes the expected
// output tuple and the clk200 edge on which it must appear; a monitor pops
// an entry each time the registered outputs change.
module tb_ddr2_idelay_rst_seq;

    logic       clk200 = 1'b0;
    logic       rst200;
    logic       clk_locked;
    logic       idelay_ctrl_rdy;
    logic       idelay_rst;
    logic       iodelay_ready;
    logic       timeout_err;
    logic [1:0] retry_count;

    ddr2_idelay_rst_seq dut (
        .clk200          (clk200),
        .rst200          (rst200),
        .clk_locked      (clk_locked),
        .idelay_ctrl_rdy (idelay_ctrl_rdy),
        .idelay_rst      (idelay_rst),
        .iodelay_ready   (iodelay_ready),
        .timeout_err     (timeout_err),
        .retry_count     (retry_count)
    );

    always #5 clk200 = ~clk200;

    typedef struct packed {
        logic [31:0] at;
        logic [4:0]  outs;   // {idelay_rst, iodelay_ready, timeout_err, retry_count}
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;
    int   n_exp  = 0;
    logic done   = 1'b0;
    logic [4:0] prev = 5'bxxxxx;

    always @(posedge clk200) cyc <= cyc + 1;

    task automatic expect_at(input int at, input logic r, input logic rd,
                             input logic e, input logic [1:0] rc);
        exp_t x;
        x.at   = 32'(at);
        x.outs = {r, rd, e, rc};
        exp_q.push_back(x);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk200);
            #1;
        end
    endtask

    // Monitor: compare every output change against the head of the queue
    always @(negedge clk200) begin
        logic [4:0] obs;
        exp_t       e;
        obs = {idelay_rst, iodelay_ready, timeout_err, retry_count};
        if (obs !== prev) begin
            prev   = obs;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_change cycle %0d: got outs=%b, required no change",
                         cyc, obs);
            end else begin
                e = exp_q.pop_front();
                n_exp = n_exp + 1;
                if (e.outs !== obs || e.at != 32'(cyc))
                    $display("FAIL evt%0d: got outs=%b at cycle %0d, required outs=%b at cycle %0d",
                             n_exp, obs, cyc, e.outs, e.at);
                else
                    passed = passed + 1;
            end
        end
        if (done) begin
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                $display("FAIL missing_evt: got no change, required outs=%b at cycle %0d",
                         e.outs, e.at);
            end
            $display("%0d/%0d checks passed", passed, checks);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, w, j, a, b, p, c, d, f;
        rst200          = 1'b1;
        clk_locked      = 1'b0;
        idelay_ctrl_rdy = 1'b0;

        // Reset state appears on the first edge
        expect_at(1, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(5);
        rst200 = 1'b0;

        // Power-up: lock -> 2 sync + 16 settle + 12 pulse, then RDY
        wait_until(8);
        k = cyc;
        clk_locked = 1'b1;
        w = k + 31;
        expect_at(w, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_until(w + 20);
        idelay_ctrl_rdy = 1'b1;
        expect_at(w + 23, 1'b0, 1'b1, 1'b0, 2'd0);

        // One-cycle RDY glitch in READY -> reset pulse and re-entry
        wait_until(w + 40);
        j = cyc;
        idelay_ctrl_rdy = 1'b0;
        expect_at(j + 3,  1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(j + 15, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(j + 16, 1'b0, 1'b1, 1'b0, 2'd0);
        wait_until(j + 1);
        idelay_ctrl_rdy = 1'b1;

        // Lock loss in READY
        wait_until(j + 30);
        a = cyc;
        clk_locked = 1'b0;
        expect_at(a + 3, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(a + 5);
        idelay_ctrl_rdy = 1'b0;

        // Relock, one timeout, then lock loss inside the retry pulse
        wait_until(a + 10);
        b = cyc;
        clk_locked = 1'b1;
        w = b + 31;
        expect_at(w, 1'b0, 1'b0, 1'b0, 2'd0);
        p = w + 1024;
        expect_at(p, 1'b1, 1'b0, 1'b0, 2'd1);
        wait_until(p + 5);
        clk_locked = 1'b0;
        expect_at(p + 8, 1'b1, 1'b0, 1'b0, 2'd0);

        // Full rerun on relock; RDY arrives on the second attempt
        wait_until(p + 15);
        c = cyc;
        clk_locked = 1'b1;
        w = c + 31;
        expect_at(w,        1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(w + 1024, 1'b1, 1'b0, 1'b0, 2'd1);
        expect_at(w + 1036, 1'b0, 1'b0, 1'b0, 2'd1);
        wait_until(w + 1036 + 50);
        idelay_ctrl_rdy = 1'b1;
        expect_at(w + 1036 + 53, 1'b0, 1'b1, 1'b0, 2'd1);

        // rst200 from READY clears retry_count; lock still high so it restarts
        wait_until(w + 1036 + 70);
        d = cyc;
        rst200 = 1'b1;
        idelay_ctrl_rdy = 1'b0;
        expect_at(d + 1, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(d + 1);
        rst200 = 1'b0;
        w = d + 32;
        expect_at(w, 1'b0, 1'b0, 1'b0, 2'd0);

        // One-cycle rst200 in WAIT_RDY at counter 500
        wait_until(w + 500);
        rst200 = 1'b1;
        expect_at(w + 501, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(w + 501);
        rst200 = 1'b0;
        k = cyc;

        // RDY never comes: three retries, then fatal
        w = k + 31;
        expect_at(w, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int r = 1; r <= 3; r++) begin
            expect_at(w + 1024, 1'b1, 1'b0, 1'b0, 2'(r));
            expect_at(w + 1036, 1'b0, 1'b0, 1'b0, 2'(r));
            w = w + 1036;
        end
        f = w + 1024;
        expect_at(f, 1'b1, 1'b0, 1'b1, 2'd3);

        // Lock loss is ignored in FAIL; only rst200 clears it
        wait_until(f + 10);
        clk_locked = 1'b0;
        wait_until(f + 30);
        rst200 = 1'b1;
        expect_at(f + 31, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_until(f + 31);
        rst200 = 1'b0;

        wait_until(f + 60);
        done = 1'b1;
    end

endmodule
